// File: rtl/id_ex_elastic_stage_pkg.sv
// ----------------------------------------------------------------------------
// id_ex_elastic_stage_pkg
// Shared definitions for the ID->EX elastic boundary and its neighbours:
//   - default datapath / index / control / counter widths
//   - bit positions of the write-enables inside the packed control bundle
//     (MSB first: RegWrite, ALUSrc, MemWrite, ...)
//   - occupancy state encoding of the two-entry stage
// ----------------------------------------------------------------------------
package id_ex_elastic_stage_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;
    localparam int CTRL_W_DEF = 13;
    localparam int CNT_W_DEF  = 16;

    // Write-enable positions inside the control bundle; these are the bits
    // that must never leak into execute on a bubble.
    localparam int CTRL_REGWRITE = CTRL_W_DEF - 1;
    localparam int CTRL_MEMWRITE = CTRL_W_DEF - 3;

    // How many of the two entries (main, skid) currently hold an instruction.
    // The skid entry is only ever occupied while the main entry is.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/id_ex_elastic_stage_sat_counter.sv
// ----------------------------------------------------------------------------
// id_ex_elastic_stage_sat_counter
// Saturating event counter used for the stall / bubble performance counters.
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-low reset (clears the count)
//   inc   - count one event this cycle
//   clr   - synchronous clear, wins over inc
//   count - current count, sticks at all-ones
// ----------------------------------------------------------------------------
module id_ex_elastic_stage_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/id_ex_elastic_stage.sv
// ----------------------------------------------------------------------------
// id_ex_elastic_stage
// ID->EX pipeline boundary built as a valid/ready elastic stage with a
// two-entry skid buffer. The main entry drives execute; the skid entry
// catches the one instruction that can arrive while execute stalls, which
// lets in_ready be a function of registered state only (no path from
// out_ready). Bubbles are qualified so control and register indices read 0
// whenever out_valid is low.
// Ports:
//   clk, rst                 - clock, synchronous active-low reset
//   in_valid / in_ready      - handshake with decode
//   in_ctrl, in_rd1, in_rd2, in_imm, in_pc, in_pcplus4, in_rs1, in_rs2, in_rd
//                            - decoded instruction payload
//   flush                    - drop everything held and incoming
//   out_valid / out_ready    - handshake with execute
//   out_*                    - held payload (ctrl and indices zero on bubble)
//   perf_clr                 - clears both performance counters
//   stall_cnt, bubble_cnt    - saturating stall / bubble cycle counters
// ----------------------------------------------------------------------------
module id_ex_elastic_stage
    import id_ex_elastic_stage_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [XLEN-1:0]   in_rd1,
    input  logic [XLEN-1:0]   in_rd2,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_pcplus4,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [XLEN-1:0]   out_rd1,
    output logic [XLEN-1:0]   out_rd2,
    output logic [XLEN-1:0]   out_imm,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_pcplus4,
    output logic [REG_AW-1:0] out_rs1,
    output logic [REG_AW-1:0] out_rs2,
    output logic [REG_AW-1:0] out_rd,
    input  logic              perf_clr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam int PAY_W = CTRL_W + 3 * REG_AW + 5 * XLEN;

    occ_e             r_occ;
    occ_e             w_nextOcc;
    logic [PAY_W-1:0] r_mainPay;
    logic [PAY_W-1:0] r_skidPay;
    logic [PAY_W-1:0] w_inPay;

    logic w_inReady;
    logic w_outValid;
    logic w_accept;
    logic w_drain;
    logic w_loadMainFromIn;
    logic w_loadMainFromSkid;
    logic w_loadSkid;

    logic [CTRL_W-1:0] w_mainCtrl;
    logic [REG_AW-1:0] w_mainRs1;
    logic [REG_AW-1:0] w_mainRs2;
    logic [REG_AW-1:0] w_mainRd;

    assign w_inPay = {in_ctrl, in_rs1, in_rs2, in_rd,
                      in_rd1, in_rd2, in_imm, in_pc, in_pcplus4};

    assign {w_mainCtrl, w_mainRs1, w_mainRs2, w_mainRd,
            out_rd1, out_rd2, out_imm, out_pc, out_pcplus4} = r_mainPay;

    // in_ready depends only on the skid register; gating with rst keeps
    // decode from handing over anything while reset is held.
    assign w_inReady  = rst && (r_occ != OCC_TWO);
    assign w_outValid = (r_occ != OCC_EMPTY);
    assign w_accept   = in_valid && w_inReady;
    assign w_drain    = w_outValid && out_ready;

    assign in_ready  = w_inReady;
    assign out_valid = w_outValid;
    assign out_ctrl  = w_outValid ? w_mainCtrl : '0;
    assign out_rs1   = w_outValid ? w_mainRs1  : '0;
    assign out_rs2   = w_outValid ? w_mainRs2  : '0;
    assign out_rd    = w_outValid ? w_mainRd   : '0;

    // Occupancy register. Flush sits just below reset and empties both entries.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_occ <= OCC_EMPTY;
        end else if (flush) begin
            r_occ <= OCC_EMPTY;
        end else begin
            r_occ <= w_nextOcc;
        end
    end

    // Next occupancy and which entry loads from where. With both entries full
    // in_ready is low, so a drain there can only shift skid into main.
    always_comb begin
        w_nextOcc          = r_occ;
        w_loadMainFromIn   = 1'b0;
        w_loadMainFromSkid = 1'b0;
        w_loadSkid         = 1'b0;
        case (r_occ)
            OCC_EMPTY: begin
                if (w_accept) begin
                    w_nextOcc        = OCC_ONE;
                    w_loadMainFromIn = 1'b1;
                end
            end
            OCC_ONE: begin
                if (w_drain && w_accept) begin
                    w_loadMainFromIn = 1'b1;
                end else if (w_drain) begin
                    w_nextOcc = OCC_EMPTY;
                end else if (w_accept) begin
                    w_nextOcc  = OCC_TWO;
                    w_loadSkid = 1'b1;
                end
            end
            OCC_TWO: begin
                if (w_drain) begin
                    w_nextOcc          = OCC_ONE;
                    w_loadMainFromSkid = 1'b1;
                end
            end
            default: begin
                w_nextOcc = OCC_EMPTY;
            end
        endcase
    end

    // Payload registers; cleared on reset and flush so nothing stale survives.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_mainPay <= '0;
            r_skidPay <= '0;
        end else begin
            if (w_loadMainFromIn) begin
                r_mainPay <= w_inPay;
            end else if (w_loadMainFromSkid) begin
                r_mainPay <= r_skidPay;
            end
            if (w_loadSkid) begin
                r_skidPay <= w_inPay;
            end
        end
    end

    id_ex_elastic_stage_sat_counter #(.CNT_W(CNT_W)) u_stallCnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_outValid && !out_ready),
        .clr   (perf_clr),
        .count (stall_cnt)
    );

    id_ex_elastic_stage_sat_counter #(.CNT_W(CNT_W)) u_bubbleCnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (!w_outValid),
        .clr   (perf_clr),
        .count (bubble_cnt)
    );

endmodule

// File: tb/tb_id_ex_elastic_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_elastic_stage
// Directed table of single-cycle vectors, hand sequences for counters and
// reset-during-stall, and a random valid/ready/flush run against an
// in-order queue model. A second instance with 4-bit counters shares the
// stimulus so counter saturation can be observed.
// ----------------------------------------------------------------------------
module tb_id_ex_elastic_stage;
    import id_ex_elastic_stage_pkg::*;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int CTRL_W = 13;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [XLEN-1:0]   in_rd1, in_rd2, in_imm, in_pc, in_pcplus4;
    logic [REG_AW-1:0] in_rs1, in_rs2, in_rd;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [XLEN-1:0]   out_rd1, out_rd2, out_imm, out_pc, out_pcplus4;
    logic [REG_AW-1:0] out_rs1, out_rs2, out_rd;
    logic              perf_clr;
    logic [CNT_W-1:0]  stall_cnt, bubble_cnt;

    logic              sIn_ready, sOut_valid;
    logic [CTRL_W-1:0] sOut_ctrl;
    logic [XLEN-1:0]   sOut_rd1, sOut_rd2, sOut_imm, sOut_pc, sOut_pcplus4;
    logic [REG_AW-1:0] sOut_rs1, sOut_rs2, sOut_rd;
    logic [3:0]        sStall_cnt, sBubble_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_elastic_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
        .in_rd1(in_rd1), .in_rd2(in_rd2), .in_imm(in_imm), .in_pc(in_pc),
        .in_pcplus4(in_pcplus4), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_rd1(out_rd1), .out_rd2(out_rd2), .out_imm(out_imm), .out_pc(out_pc),
        .out_pcplus4(out_pcplus4), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .perf_clr(perf_clr), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    id_ex_elastic_stage #(.CNT_W(4)) dutSmall (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(sIn_ready), .in_ctrl(in_ctrl),
        .in_rd1(in_rd1), .in_rd2(in_rd2), .in_imm(in_imm), .in_pc(in_pc),
        .in_pcplus4(in_pcplus4), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .flush(flush),
        .out_valid(sOut_valid), .out_ready(out_ready), .out_ctrl(sOut_ctrl),
        .out_rd1(sOut_rd1), .out_rd2(sOut_rd2), .out_imm(sOut_imm), .out_pc(sOut_pc),
        .out_pcplus4(sOut_pcplus4), .out_rs1(sOut_rs1), .out_rs2(sOut_rs2), .out_rd(sOut_rd),
        .perf_clr(perf_clr), .stall_cnt(sStall_cnt), .bubble_cnt(sBubble_cnt)
    );

    // Every payload field is derived from the PC so a held instruction can be
    // recognised from out_pc alone. RegWrite (MSB) is always set.
    function automatic logic [CTRL_W-1:0] ctrlOf(input logic [XLEN-1:0] pc);
        return {1'b1, pc[13:2]};
    endfunction
    function automatic logic [XLEN-1:0] rd1Of(input logic [XLEN-1:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction
    function automatic logic [XLEN-1:0] rd2Of(input logic [XLEN-1:0] pc);
        return ~pc;
    endfunction
    function automatic logic [XLEN-1:0] immOf(input logic [XLEN-1:0] pc);
        return pc + 32'h0000_1000;
    endfunction
    function automatic logic [REG_AW-1:0] rdOf(input logic [XLEN-1:0] pc);
        return pc[6:2] ^ 5'h1f;
    endfunction

    typedef struct {
        logic        inValid;
        logic        outReady;
        logic        flush;
        logic [31:0] pc;
        logic        expValid;
        logic [31:0] expPc;
        logic        expInReady;
        logic        expCleared;
    } vec_t;

    vec_t vecs[$];

    // Compare one value and report it.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, clock once, and settle just after the edge.
    task automatic applyStimulus(input logic v, input logic r, input logic f,
                                 input logic [31:0] pc);
        in_valid   = v;
        out_ready  = r;
        flush      = f;
        in_pc      = pc;
        in_pcplus4 = pc + 32'd4;
        in_ctrl    = ctrlOf(pc);
        in_rd1     = rd1Of(pc);
        in_rd2     = rd2Of(pc);
        in_imm     = immOf(pc);
        in_rs1     = pc[6:2];
        in_rs2     = pc[7:3];
        in_rd      = rdOf(pc);
        @(posedge clk);
        #1;
    endtask

    // Check the main entry against an expected instruction or a bubble.
    task automatic checkEntry(input string tag, input logic expValid,
                              input logic [31:0] expPc);
        checkOutput({tag, " out_valid"}, out_valid, expValid);
        if (expValid) begin
            checkOutput({tag, " out_pc"}, out_pc, expPc);
            checkOutput({tag, " out_ctrl"}, out_ctrl, ctrlOf(expPc));
            checkOutput({tag, " out_rd1"}, out_rd1, rd1Of(expPc));
            checkOutput({tag, " out_rd2"}, out_rd2, rd2Of(expPc));
            checkOutput({tag, " out_imm"}, out_imm, immOf(expPc));
            checkOutput({tag, " out_pcplus4"}, out_pcplus4, expPc + 32'd4);
            checkOutput({tag, " out_rs1"}, out_rs1, expPc[6:2]);
            checkOutput({tag, " out_rs2"}, out_rs2, expPc[7:3]);
            checkOutput({tag, " out_rd"}, out_rd, rdOf(expPc));
        end else begin
            checkOutput({tag, " bubble out_ctrl"}, out_ctrl, 0);
            checkOutput({tag, " bubble out_rs1"}, out_rs1, 0);
            checkOutput({tag, " bubble out_rs2"}, out_rs2, 0);
            checkOutput({tag, " bubble out_rd"}, out_rd, 0);
        end
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] seqPc;
        logic        v, r, f, d, a;

        // Streaming: each instruction appears one cycle after acceptance.
        for (int i = 0; i < 8; i++) begin
            vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h100 + 32'(4 * i),
                             1'b1, 32'h100 + 32'(4 * i), 1'b1, 1'b0});
        end
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0});
        // Stall: 0x0 in main, 0x4 in skid, 0x8 refused until a slot frees.
        vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h4, 1'b1, 32'h0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h8, 1'b1, 32'h0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h8, 1'b1, 32'h4, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h8, 1'b1, 32'h8, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0});
        // Flush with both entries full, in_valid and out_ready high.
        vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h20, 1'b1, 32'h20, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h24, 1'b1, 32'h20, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 32'h28, 1'b0, 32'h0, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h2c, 1'b1, 32'h2c, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0});
        // Flush while empty drops the incoming instruction.
        vecs.push_back('{1'b1, 1'b1, 1'b1, 32'h30, 1'b0, 32'h0, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1});

        rst      = 1'b0;
        perf_clr = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset in_ready", in_ready, 0);
        checkOutput("reset out_pc", out_pc, 0);
        checkOutput("reset out_ctrl", out_ctrl, 0);
        checkOutput("reset stall_cnt", stall_cnt, 0);
        checkOutput("reset bubble_cnt", bubble_cnt, 0);
        rst = 1'b1;
        #1;
        checkOutput("release in_ready", in_ready, 1);

        $display("[TB] directed vectors");
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].inValid, vecs[i].outReady, vecs[i].flush, vecs[i].pc);
            checkEntry($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expPc);
            checkOutput($sformatf("vec%0d in_ready", i), in_ready, vecs[i].expInReady);
            if (vecs[i].expCleared) begin
                checkOutput($sformatf("vec%0d cleared out_pc", i), out_pc, 0);
                checkOutput($sformatf("vec%0d cleared out_rd1", i), out_rd1, 0);
            end
        end

        $display("[TB] counters");
        perf_clr = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h40);
        perf_clr = 1'b0;
        checkOutput("clr stall_cnt", stall_cnt, 0);
        checkOutput("clr bubble_cnt", bubble_cnt, 0);
        repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkEntry("stall10", 1'b1, 32'h40);
        checkOutput("stall10 stall_cnt", stall_cnt, 10);
        checkOutput("stall10 small stall_cnt", sStall_cnt, 10);
        checkOutput("stall10 bubble_cnt", bubble_cnt, 0);
        repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("stall20 stall_cnt", stall_cnt, 20);
        checkOutput("stall20 small stall_cnt saturated", sStall_cnt, 15);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkEntry("drain40", 1'b0, 32'h0);
        checkOutput("drain stall_cnt", stall_cnt, 20);
        checkOutput("drain bubble_cnt", bubble_cnt, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("idle bubble_cnt", bubble_cnt, 1);
        checkOutput("idle small bubble_cnt", sBubble_cnt, 1);

        $display("[TB] reset during stall");
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h50);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h54);
        checkOutput("prerst in_ready", in_ready, 0);
        checkOutput("prerst out_pc", out_pc, 32'h50);
        rst = 1'b0;
        #1;
        checkOutput("rst held in_ready", in_ready, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h58);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h58);
        checkEntry("midrst", 1'b0, 32'h0);
        checkOutput("midrst out_pc", out_pc, 0);
        checkOutput("midrst out_rd1", out_rd1, 0);
        checkOutput("midrst in_ready", in_ready, 0);
        checkOutput("midrst stall_cnt", stall_cnt, 0);
        checkOutput("midrst bubble_cnt", bubble_cnt, 0);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkEntry("postrst", 1'b0, 32'h0);
        checkOutput("postrst in_ready", in_ready, 1);
        checkOutput("postrst bubble_cnt", bubble_cnt, 1);
        checkOutput("postrst stall_cnt", stall_cnt, 0);

        $display("[TB] random traffic");
        seqPc = 32'h1000;
        for (int c = 0; c < 3000; c++) begin
            checkOutput("rand out_valid", out_valid, q.size() > 0);
            checkOutput("rand in_ready", in_ready, q.size() < 2);
            if (q.size() > 0) begin
                checkOutput("rand out_pc", out_pc, q[0]);
                checkOutput("rand out_ctrl", out_ctrl, ctrlOf(q[0]));
            end else begin
                checkOutput("rand bubble RegWrite", out_ctrl[CTRL_REGWRITE], 0);
                checkOutput("rand bubble MemWrite", out_ctrl[CTRL_MEMWRITE], 0);
            end
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            f = ($urandom_range(0, 19) == 0);
            if (f) begin
                q.delete();
            end else begin
                d = (q.size() > 0) && r;
                a = v && (q.size() < 2);
                if (d) void'(q.pop_front());
                if (a) q.push_back(seqPc);
            end
            applyStimulus(v, r, f, seqPc);
            seqPc = seqPc + 32'd4;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
